operand_fetch: RTL

Operand-fetch stage of the TinyCPU pipeline. It sits between decode and execute and is the read-side client of the 8×8 register file. It drives the two asynchronous read addresses and bypasses a same-cycle writeback. It also tracks a scoreboard of pending destination registers to stall on RAW/WAW hazards, and presents fetched operands to execute through a one-entry valid/ready output register.

---
 rtl/operand_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage: register-file read with writeback bypass,
// pending-writer scoreboard for RAW/WAW stalls, one-entry valid/ready output register.
module operand_fetch #(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [2:0]     in_src_a,
  input  logic [2:0]     in_src_b,
  input  logic           in_use_a,
  input  logic           in_use_b,
  input  logic [2:0]     in_dst,
  input  logic           in_dst_en,
  output logic [2:0]     rf_addr_a,
  output logic [2:0]     rf_addr_b,
  input  logic [7:0]     rf_data_a,
  input  logic [7:0]     rf_data_b,
  input  logic           wb_we,
  input  logic [2:0]     wb_addr,
  input  logic [7:0]     wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_op,
  output logic [7:0]     out_a,
  output logic [7:0]     out_b,
  output logic [2:0]     out_dst,
  output logic           out_dst_en,
  output logic [7:0]     busy
);

  logic           out_valid_q;
  logic [OPW-1:0] out_op_q;
  logic [7:0]     out_a_q;
  logic [7:0]     out_b_q;
  logic [2:0]     out_dst_q;
  logic           out_dst_en_q;
  logic [7:0]     busy_q;
  logic [7:0]     busy_d;

  logic [7:0]     opnd_a;
  logic [7:0]     opnd_b;
  logic [7:0]     clr;
  logic [7:0]     eff_busy;
  logic [7:0]     set_vec;
  logic           hazard;
  logic           accept;

  assign rf_addr_a = in_src_a;
  assign rf_addr_b = in_src_b;

  // The register file only updates at the edge, so a same-cycle writeback must be forwarded.
  assign opnd_a = (wb_we && (wb_addr == in_src_a)) ? wb_data : rf_data_a;
  assign opnd_b = (wb_we && (wb_addr == in_src_b)) ? wb_data : rf_data_b;

  always_comb begin
    clr = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clr[i] = wb_we && (wb_addr == 3'(i));
    end
  end

  assign eff_busy = busy_q & ~clr;

  assign hazard = (in_use_a  && eff_busy[in_src_a]) ||
                  (in_use_b  && eff_busy[in_src_b]) ||
                  (in_dst_en && eff_busy[in_dst]);

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // OR-ing the set after masking the clear lets a new writer win over a retiring one.
  assign set_vec = (accept && in_dst_en) ? (8'h01 << in_dst) : 8'h00;
  assign busy_d  = (busy_q & ~clr) | set_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_a_q      <= 8'h00;
      out_b_q      <= 8'h00;
      out_dst_q    <= 3'd0;
      out_dst_en_q <= 1'b0;
      busy_q       <= 8'h00;
    end else begin
      if (accept) begin
        out_valid_q  <= 1'b1;
        out_op_q     <= in_op;
        out_a_q      <= opnd_a;
        out_b_q      <= opnd_b;
        out_dst_q    <= in_dst;
        out_dst_en_q <= in_dst_en;
      end else if (out_ready) begin
        out_valid_q  <= 1'b0;
      end
      busy_q <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_dst    = out_dst_q;
  assign out_dst_en = out_dst_en_q;
  assign busy       = busy_q;

endmodule
